// File: rtl/controller_if.sv
// Bundle between the ktc32 multicycle controller and its datapath/memory side.
// The master modport belongs to the controller; the slave modport is the datapath view.
interface controller_if;
  logic [31:0] instr;
  logic        flag;
  logic        mem_ready;
  logic        pcen;
  logic        iord;
  logic        regdst;
  logic [1:0]  memtoreg;
  logic [1:0]  alusrca;
  logic [1:0]  alusrcb;
  logic [4:0]  alucontrol;
  logic        pcsrc;
  logic        irwrite;
  logic [2:0]  regwrite;
  logic        memreq;
  logic        memwrite;
  logic [1:0]  memsize;
  logic        halted;
  logic        illegal;

  modport master (
    input  instr, flag, mem_ready,
    output pcen, iord, regdst, memtoreg, alusrca, alusrcb, alucontrol,
           pcsrc, irwrite, regwrite, memreq, memwrite, memsize, halted, illegal
  );

  modport slave (
    output instr, flag, mem_ready,
    input  pcen, iord, regdst, memtoreg, alusrca, alusrcb, alucontrol,
           pcsrc, irwrite, regwrite, memreq, memwrite, memsize, halted, illegal
  );
endinterface

// File: rtl/controller.sv
// Multicycle control FSM for the ktc32 core, handling mixed 16/32-bit instructions.
// State and the sticky illegal flag are registered; strobes follow the current state.
module controller (
  input  logic         clk,
  input  logic         reset,
  controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, ALUR, ALUI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JALR, HALT
  } state_t;

  state_t     state;
  logic       illegal_q;
  logic       is32;
  logic [4:0] op;

  assign is32 = bus.instr[5];
  assign op   = bus.instr[4:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        FETCH:   if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          if (!is32) begin
            if (!op[4])              state <= ALUR;
            else if (op == 5'b10000) state <= JALR;
            else begin
              state     <= HALT;
              illegal_q <= 1'b1;
            end
          end else begin
            if (!op[4])                state <= ALUI;
            else if (!op[3])           state <= MEMADR;
            else if (op[2:1] != 2'b11) state <= BRANCH;
            else if (op == 5'b11110)   state <= FETCH;
            else                       state <= HALT;
          end
        end
        ALUR, ALUI:                  state <= ALUWB;
        ALUWB, MEMWB, BRANCH, JALR:  state <= FETCH;
        MEMADR:  state <= (op <= 5'b10100) ? MEMRD : MEMWR;
        MEMRD:   if (bus.mem_ready) state <= MEMWB;
        MEMWR:   if (bus.mem_ready) state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Reset forces every strobe to its idle value, aborting any memory access in flight.
  always_comb begin
    bus.pcen       = 1'b0;
    bus.iord       = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 2'd0;
    bus.alusrca    = 2'd0;
    bus.alusrcb    = 2'd0;
    bus.alucontrol = 5'd0;
    bus.pcsrc      = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 3'b000;
    bus.memreq     = 1'b0;
    bus.memwrite   = 1'b0;
    bus.memsize    = 2'b00;
    bus.halted     = 1'b0;
    bus.illegal    = 1'b0;
    if (!reset) begin
      bus.illegal = illegal_q;
      case (state)
        FETCH: begin
          bus.memreq  = 1'b1;
          bus.alusrcb = 2'd1;
          bus.irwrite = bus.mem_ready;
          bus.pcen    = bus.mem_ready;
        end
        DECODE: begin
          bus.alusrcb = 2'd2;
          if (is32 && op == 5'b11110) begin
            bus.alusrcb  = 2'd3;
            bus.pcen     = 1'b1;
            bus.regdst   = 1'b1;
            bus.memtoreg = 2'd2;
            bus.regwrite = 3'b001;
          end
        end
        ALUR: begin
          bus.alusrca    = 2'd2;
          bus.alucontrol = {1'b0, bus.instr[3:0]};
        end
        ALUI: begin
          bus.alusrca    = 2'd2;
          bus.alusrcb    = 2'd2;
          bus.alucontrol = {1'b0, bus.instr[3:0]};
        end
        ALUWB:  bus.regwrite = 3'b001;
        MEMADR: begin
          bus.alusrca = 2'd2;
          bus.alusrcb = 2'd2;
        end
        MEMRD: begin
          bus.iord   = 1'b1;
          bus.memreq = 1'b1;
        end
        MEMWB: begin
          bus.memtoreg = 2'd1;
          case (op[2:0])
            3'b000:  bus.regwrite = 3'b001;
            3'b001:  bus.regwrite = 3'b010;
            3'b010:  bus.regwrite = 3'b011;
            3'b011:  bus.regwrite = 3'b110;
            default: bus.regwrite = 3'b111;
          endcase
        end
        MEMWR: begin
          bus.iord     = 1'b1;
          bus.memreq   = 1'b1;
          bus.memwrite = 1'b1;
          case (op[1:0])
            2'b01:   bus.memsize = 2'b00;
            2'b10:   bus.memsize = 2'b01;
            default: bus.memsize = 2'b10;
          endcase
        end
        BRANCH: begin
          bus.alusrca    = 2'd2;
          bus.alucontrol = 5'd10 + {2'b00, op[2:0]};
          bus.pcsrc      = 1'b1;
          bus.pcen       = bus.flag;
        end
        JALR: begin
          bus.alusrca    = 2'd2;
          bus.alucontrol = 5'd16;
          bus.pcen       = 1'b1;
          bus.regdst     = 1'b1;
          bus.memtoreg   = 2'd2;
          bus.regwrite   = 3'b001;
        end
        HALT:    bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controller.sv
// Bench for the ktc32 controller: an instruction-level step model checked every cycle,
// directed sequences with literal expectations, then randomized instruction streams.
module tb_controller;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       regdst;
    logic [1:0] memtoreg;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [4:0] alucontrol;
    logic       pcsrc;
    logic       irwrite;
    logic [2:0] regwrite;
    logic       memreq;
    logic       memwrite;
    logic [1:0] memsize;
    logic       halted;
    logic       illegal;
  } ctl_t;

  typedef enum {K_ALUR, K_ALUI, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_HALT, K_ILL} kind_t;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_word;
  int          checks;
  int          errors;

  controller_if bus ();

  controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic kind_t kind_of(input logic [31:0] word);
    int op;
    op = int'(word[4:0]);
    if (!word[5]) return (op < 16) ? K_ALUR : (op == 16) ? K_JALR : K_ILL;
    if (op < 16)  return K_ALUI;
    if (op <= 20) return K_LOAD;
    if (op <= 23) return K_STORE;
    if (op <= 29) return K_BR;
    if (op == 30) return K_JAL;
    return K_HALT;
  endfunction

  // Reference model: position within the current instruction (0 fetch, 1 decode, 2.. per kind).
  initial begin : compare_proc
    int    step;
    int    nstep;
    bit    m_halt;
    bit    m_ill;
    bit    n_halt;
    bit    n_ill;
    int    op;
    int    load_rw [5];
    kind_t k;
    ctl_t  e;
    ctl_t  a;
    step    = 0;
    m_halt  = 0;
    m_ill   = 0;
    load_rw = '{1, 2, 3, 6, 7};
    bus.instr = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      e      = '0;
      nstep  = step;
      n_halt = m_halt;
      n_ill  = m_ill;
      op     = int'(bus.instr[4:0]);
      k      = kind_of(bus.instr);
      if (reset) begin
        nstep  = 0;
        n_halt = 0;
        n_ill  = 0;
      end else if (m_halt) begin
        e.halted  = 1'b1;
        e.illegal = m_ill;
      end else begin
        case (step)
          0: begin
            e.memreq  = 1'b1;
            e.alusrcb = 2'd1;
            e.irwrite = bus.mem_ready;
            e.pcen    = bus.mem_ready;
            nstep     = bus.mem_ready ? 1 : 0;
          end
          1: begin
            e.alusrcb = 2'd2;
            nstep     = 2;
            if (k == K_JAL) begin
              e.alusrcb  = 2'd3;
              e.pcen     = 1'b1;
              e.regdst   = 1'b1;
              e.memtoreg = 2'd2;
              e.regwrite = 3'd1;
              nstep      = 0;
            end else if (k == K_HALT || k == K_ILL) begin
              n_halt = 1;
              n_ill  = (k == K_ILL);
              nstep  = 0;
            end
          end
          2: begin
            e.alusrca = 2'd2;
            nstep     = 3;
            case (k)
              K_ALUR: e.alucontrol = 5'(op % 16);
              K_ALUI: begin
                e.alusrcb    = 2'd2;
                e.alucontrol = 5'(op % 16);
              end
              K_LOAD, K_STORE: e.alusrcb = 2'd2;
              K_BR: begin
                e.alucontrol = 5'(10 + op - 24);
                e.pcsrc      = 1'b1;
                e.pcen       = bus.flag;
                nstep        = 0;
              end
              default: begin
                e.alucontrol = 5'd16;
                e.pcen       = 1'b1;
                e.regdst     = 1'b1;
                e.memtoreg   = 2'd2;
                e.regwrite   = 3'd1;
                nstep        = 0;
              end
            endcase
          end
          3: begin
            if (k == K_ALUR || k == K_ALUI) begin
              e.regwrite = 3'd1;
              nstep      = 0;
            end else begin
              e.iord   = 1'b1;
              e.memreq = 1'b1;
              if (k == K_STORE) begin
                e.memwrite = 1'b1;
                e.memsize  = 2'(op - 21);
                nstep      = bus.mem_ready ? 0 : 3;
              end else begin
                nstep = bus.mem_ready ? 4 : 3;
              end
            end
          end
          default: begin
            e.memtoreg = 2'd1;
            e.regwrite = 3'(load_rw[op - 16]);
            nstep      = 0;
          end
        endcase
      end
      a = {bus.pcen, bus.iord, bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb,
           bus.alucontrol, bus.pcsrc, bus.irwrite, bus.regwrite, bus.memreq,
           bus.memwrite, bus.memsize, bus.halted, bus.illegal};
      checks++;
      if (a !== e) begin
        errors++;
        $display("[TB] FAIL model_cycle t=%0t step=%0d instr=%h actual=%h expected=%h",
                 $time, step, bus.instr, a, e);
      end
      @(posedge clk);
      step   = nstep;
      m_halt = n_halt;
      m_ill  = n_ill;
      if (e.irwrite) bus.instr <= fetch_word;
    end
  end

  task automatic applyStimulus(input logic r, input logic mr, input logic fl);
    @(negedge clk);
    reset         = r;
    bus.mem_ready = mr;
    bus.flag      = fl;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic fetchInstr(input logic [31:0] word);
    fetch_word = word;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("fetch_memreq", 8'(bus.memreq), 8'd1);
    checkOutput("fetch_irwrite", 8'(bus.irwrite), 8'd1);
  endtask

  function automatic logic [31:0] random_instr();
    logic [31:0] w;
    logic [5:0]  low;
    w   = $urandom;
    low = 6'($urandom_range(0, 63));
    if ((low == 6'h3F || (!low[5] && low[4] && low[3:0] != 4'h0)) && $urandom_range(0, 3) != 0)
      low[4] = 1'b0;
    return {w[31:6], low};
  endfunction

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.flag      = 1'b0;
    fetch_word    = 32'h0;

    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("reset_memreq", 8'(bus.memreq), 8'd0);
    checkOutput("reset_halted", 8'(bus.halted), 8'd0);

    fetchInstr(32'h0000_0880);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("alur_alucontrol", 8'(bus.alucontrol), 8'd0);
    checkOutput("alur_alusrca", 8'(bus.alusrca), 8'd2);
    checkOutput("alur_alusrcb", 8'(bus.alusrcb), 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("aluwb_regwrite", 8'(bus.regwrite), 8'd1);
    checkOutput("aluwb_regdst", 8'(bus.regdst), 8'd0);

    fetchInstr(32'h0010_1930);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("memadr_alusrcb", 8'(bus.alusrcb), 8'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, (i == 2), 1'b0);
      checkOutput("memrd_iord", 8'(bus.iord), 8'd1);
      checkOutput("memrd_memreq", 8'(bus.memreq), 8'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lw_regwrite", 8'(bus.regwrite), 8'd1);
    checkOutput("lw_memtoreg", 8'(bus.memtoreg), 8'd1);

    fetchInstr(32'h0000_0034);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lbu_regwrite", 8'(bus.regwrite), 8'd7);

    fetchInstr(32'h0000_0037);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, (i == 2), 1'b0);
      checkOutput("sb_memwrite", 8'(bus.memwrite), 8'd1);
      checkOutput("sb_memsize", 8'(bus.memsize), 8'd2);
      checkOutput("sb_pcen", 8'(bus.pcen), 8'd0);
      checkOutput("sb_regwrite", 8'(bus.regwrite), 8'd0);
    end

    fetchInstr(32'h0000_0038);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("beq_alucontrol", 8'(bus.alucontrol), 8'd10);
    checkOutput("beq_pcsrc", 8'(bus.pcsrc), 8'd1);
    checkOutput("beq_taken_pcen", 8'(bus.pcen), 8'd1);
    fetchInstr(32'h0000_0038);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("beq_untaken_pcen", 8'(bus.pcen), 8'd0);

    fetchInstr(32'h0000_003E);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("jal_pcen", 8'(bus.pcen), 8'd1);
    checkOutput("jal_alusrcb", 8'(bus.alusrcb), 8'd3);
    checkOutput("jal_regdst", 8'(bus.regdst), 8'd1);
    checkOutput("jal_memtoreg", 8'(bus.memtoreg), 8'd2);
    checkOutput("jal_regwrite", 8'(bus.regwrite), 8'd1);

    fetchInstr(32'h0000_0010);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("jalr_alucontrol", 8'(bus.alucontrol), 8'd16);

    fetchInstr(32'h0000_003F);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, logic'(i % 2), 1'b0);
      checkOutput("halt_halted", 8'(bus.halted), 8'd1);
      checkOutput("halt_illegal", 8'(bus.illegal), 8'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("halt_reset_halted", 8'(bus.halted), 8'd0);

    fetchInstr(32'h0000_0011);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ill_halted", 8'(bus.halted), 8'd1);
    checkOutput("ill_illegal", 8'(bus.illegal), 8'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ill_reset_halted", 8'(bus.halted), 8'd0);
    checkOutput("ill_reset_illegal", 8'(bus.illegal), 8'd0);
    checkOutput("ill_reset_memreq", 8'(bus.memreq), 8'd0);
    fetchInstr(32'h0000_0035);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sw_memwrite", 8'(bus.memwrite), 8'd1);
    checkOutput("sw_memsize", 8'(bus.memsize), 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sw_abort_memwrite", 8'(bus.memwrite), 8'd0);
    fetchInstr(32'h0000_0880);

    for (int i = 0; i < 4000; i++) begin
      fetch_word = random_instr();
      applyStimulus(logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 2) != 0),
                    logic'($urandom_range(0, 1)));
    end

    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller.md
Name: controller

Overview:
Multicycle control FSM for the ktc32 core. It sits directly upstream of the datapath: it consumes the latched instruction word, the ALU flag and the memory ready signal. It drives every datapath select and enable, plus the memory request, write and size strobes. It handles mixed 16/32-bit instructions: instr[5]=1 marks a 32-bit instruction, and the opcode is instr[4:0].

Parameters:
None. Encodings are fixed by the ISA.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
instr  in  32  instruction register contents
flag  in  1  ALU compare flag (combinational, current cycle)
mem_ready  in  1  memory completes the pending access this cycle
pcen  out  1  PC register enable
iord  out  1  address select: 0=pc, 1=aluout
regdst  out  1  write register: 0=instr[10:6], 1=r31
memtoreg  out  2  write data: 0=aluout, 1=data, 2=pc
alusrca  out  2  0=pc, 1=zext instr[15:11], 2=a
alusrcb  out  2  0=b, 1=pc increment, 2=sext imm16, 3=sext imm21
alucontrol  out  5  ALU op
pcsrc  out  1  next PC: 0=alu result, 1=aluout
irwrite  out  1  instruction register enable
regwrite  out  3  000 none, 001 word, 010 half sext, 011 byte sext, 110 half zext, 111 byte zext
memreq  out  1  memory access request
memwrite  out  1  store strobe
memsize  out  2  store size: 00 word, 01 half, 10 byte
halted  out  1  core stopped
illegal  out  1  stopped on an undefined 16-bit opcode

Behaviour:
- ALU codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, EQ=10, NE=11, LT=12, GE=13, LTU=14, GEU=15, PASSA=16.
- Decoding:
  - 16-bit 0xxxx: register ALU op {0,instr[3:0]}.
  - 16-bit 10000: JALR.
  - 16-bit 10001..11111: illegal.
  - 32-bit 0xxxx: immediate ALU op {0,instr[3:0]}.
  - 32-bit 10000..10100: LW, LH, LB, LHU, LBU.
  - 32-bit 10101..10111: SW, SH, SB.
  - 32-bit 11000..11101: BEQ, BNE, BLT, BGE, BLTU, BGEU, using ALU codes 10..15.
  - 32-bit 11110: JAL.
  - 32-bit 11111: HALT.
- Default in every state: all enables, memreq and regwrite are 0; all selects are 0; alucontrol=ADD.
- FETCH:
  - memreq=1, iord=0, alusrca=0, alusrcb=1, pcsrc=0.
  - irwrite=pcen=mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE:
  - aluout <- pc+imm16 (alusrca=0, alusrcb=2). This is the branch target; pc here is already the next-instruction address.
  - JAL completes here: alusrcb=3, pcsrc=0, pcen=1, regdst=1, memtoreg=2, regwrite=001, then FETCH. Link and PC update share one edge, so the link value is the pre-update pc.
  - Otherwise go to ALUR, ALUI, MEMADR, BRANCH, JALR or HALT.
- ALUR: alusrca=2, alusrcb=0, op; next ALUWB.
- ALUI: alusrca=2, alusrcb=2, op; next ALUWB.
- ALUWB: memtoreg=0, regdst=0, regwrite=001; next FETCH.
- MEMADR: alusrca=2, alusrcb=2, ADD; next MEMRD for loads, MEMWR for stores.
- MEMRD: iord=1, memreq=1; hold until mem_ready, then MEMWB.
- MEMWB: memtoreg=1, regdst=0, regwrite per load type; next FETCH.
- MEMWR: iord=1, memreq=1, memwrite=1, memsize per store type; hold until mem_ready, then FETCH.
- BRANCH: alusrca=2, alusrcb=0, compare op, pcsrc=1, pcen=flag; next FETCH.
- JALR: alusrca=2, PASSA, pcsrc=0, pcen=1, regdst=1, memtoreg=2, regwrite=001; next FETCH.
- HALT:
  - Absorbing state; halted=1.
  - illegal is a registered flag, set on entry from an illegal opcode; it stays set until reset.
  - Only reset leaves HALT.
- Reset:
  - On the reset edge: state <- FETCH, illegal <- 0.
  - While reset=1, all outputs are forced to the default values, including memreq=0 and halted=0.
  - Reset mid-MEMWR or mid-MEMRD aborts the access; memwrite is low in the reset cycle.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

Test Plan:
- 16-bit ADD, instr=0x00000880, mem_ready=1 -> FETCH, DECODE, ALUR, ALUWB in 4 cycles; ALUR shows alucontrol=0, alusrca=2, alusrcb=0; ALUWB shows regwrite=001, regdst=0; next cycle memreq=1.
- LW, instr=0x00101930, mem_ready low 2 cycles in MEMRD -> iord=1 and memreq=1 for 3 cycles; MEMWB regwrite=001, memtoreg=1. Repeat with LBU (op 10100) -> regwrite=111.
- SB (op 10111) -> MEMWR with memwrite=1 and memsize=10 until mem_ready; pcen and regwrite=0 throughout.
- BEQ (low bits 0x38) -> BRANCH with alucontrol=10, pcsrc=1; flag=1 gives pcen=1; flag=0 gives pcen=0; FETCH next in both cases.
- JAL (0x3E) -> DECODE shows pcen=1, alusrcb=3, regdst=1, memtoreg=2, regwrite=001; returns to FETCH after 2 total cycles. 16-bit 0x0010 (JALR) -> alucontrol=16 in the JALR state.
- Low bits 0x3F -> halted=1, illegal=0, held for 10 cycles despite mem_ready toggling. Low bits 0x11 -> halted=1, illegal=1. Reset -> both clear; FETCH with memreq=1 in the first cycle after reset.
